mux2x1_burst_arbiter: RTL
=========================

# mux2x1_burst_arbiter

Two-requester burst arbiter that shares one downstream datapath between two sources. It selects one source at a time through an internal 2-to-1 data multiplexer and holds the grant for a whole burst, delimited by a `last` flag. Between bursts it rotates priority round-robin. It sits in front of any single-port consumer (memory port, bus master, FIFO) that two producers must share.

## Interface
- `WIDTH`, 32: data width of each source and of the sink.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `a0_valid` input 1: source 0 has a beat.
- `a0_data` input WIDTH: source 0 beat data.
- `a0_last` input 1: source 0 beat is the final beat of its burst.
- `a0_ready` output 1: source 0 beat accepted this cycle when `a0_valid` is also high.
- `a1_valid`, `a1_data`, `a1_last`, `a1_ready`: same as the source 0 ports, for source 1.
- `y_valid` output 1: sink beat valid.
- `y_data` output WIDTH: sink beat data, equal to the granted source's data.
- `y_last` output 1: sink beat last flag.
- `y_ready` input 1: sink accepts the beat.
- `s` output 1: current mux select; 0 = source 0, 1 = source 1. Valid while `busy` is high.
- `busy` output 1: a grant is held (state GNT0 or GNT1).

## Operation
- **States:** IDLE, GNT0, GNT1. Registered `s` and a priority pointer `last_gnt`.
- **Arbitration** (evaluated in IDLE, and on the cycle a burst ends):
  - Only one source valid: that source wins.
  - Both sources valid: the source not equal to `last_gnt` wins.
  - Neither source valid: go to IDLE.
- **Winner update:** the winner is loaded into `s` and `last_gnt`, and the next state is GNT0 or GNT1 accordingly.
- **In GNTx:**
  - `y_valid = ax_valid`, `y_data = ax_data`, `y_last = ax_last`, `ax_ready = y_ready`.
  - The other source's ready is 0.
- **Burst end:** the handshake `y_valid & y_ready & y_last` in GNTx ends the burst and re-arbitrates that same cycle. The next burst, from either source, can start on the following cycle with no bubble.
- **Valid drop mid-burst:** if the granted source drops `valid` mid-burst, the grant is held; `y_valid` follows the source low. There is no timeout.
- **In IDLE:** `y_valid = 0`, `a0_ready = a1_ready = 0`, `y_data` = `a0_data` (s = 0), `y_last = 0`.
- **Single-beat burst:** a burst of one beat (`last` high on its first beat) is legal.
- **Datapath:** `y_data` is purely combinational from the selected source. There is no data register and no width change.

## Timing
- **Reset values:** state IDLE, `s = 0`, `last_gnt = 1` (source 0 wins the first tie), `busy = 0`, `y_valid = 0`, `y_last = 0`, `a0_ready = a1_ready = 0`.
- **Grant latency:** a request seen in IDLE at cycle N is granted in cycle N+1. The first beat can transfer in N+1 if `y_ready` is high.
- **Back-to-back:** when the last beat transfers at cycle N and the other source is valid, that source is granted in N+1.
- **Simultaneous requests in IDLE:** resolved by `last_gnt` only.
- **Simultaneous events at burst end:** a request from the source just granted competes at the burst-end cycle under normal round-robin rules. It wins only if the other source is not valid.
- **Reset mid-burst:** the next cycle is IDLE with reset values; the burst is abandoned with no completion handshake.
- **Combinational paths:** `y_ready -> ax_ready` and `ax_* -> y_*` are combinational. There is no combinational path from any input to `s` or `busy`.

## Configuration
- Macro: `MUX2X1_ARB_FIXED_PRIORITY_EN`.
- **Not defined:** round-robin as described above.
- **Defined:**
  - Source 0 always wins when both sources are valid at an arbitration point; `last_gnt` is ignored.
  - Bursts are still never preempted.
  - Reset values are unchanged.

## Test plan
- **Reset:** hold `reset` 2 cycles with both sources valid -> all outputs at reset values. Release -> GNT0 on the first cycle after release, `s = 0`.
- **Single requester:** source 1 sends a 3-beat burst (data 0xA1, 0xA2, 0xA3, last on the third beat) with `y_ready = 1` -> `busy` rises 1 cycle after valid, `y_data` = 0xA1/0xA2/0xA3 on consecutive cycles, `y_last` on the third beat, then IDLE.
- **Round-robin:** both sources continuously send 2-beat bursts -> grants alternate 0,1,0,1 with no idle cycles between bursts.
- **Backpressure and holes:** during a source 0 burst, drop `y_ready` for 3 cycles and `a0_valid` for 2 cycles; source 1 valid throughout -> `a1_ready` stays 0, no beat is lost or duplicated, and source 1 is granted only after source 0's last beat.
- **Reset mid-burst:** assert `reset` after beat 2 of a 4-beat burst -> IDLE next cycle, `y_valid = 0`; after release, source 0 wins the tie.
- **Fixed priority (macro defined):** both sources continuously send 1-beat bursts -> source 0 granted every time, source 1 never granted.

Source files
------------

// File: rtl/mux2x1_burst_arbiter_if.sv
// Bus bundle for mux2x1_burst_arbiter: two burst sources, one sink, grant status.
// The slave modport is the arbiter's view; master is the sources/sink side.
interface mux2x1_burst_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             a0_valid;
    logic [WIDTH-1:0] a0_data;
    logic             a0_last;
    logic             a0_ready;

    logic             a1_valid;
    logic [WIDTH-1:0] a1_data;
    logic             a1_last;
    logic             a1_ready;

    logic             y_valid;
    logic [WIDTH-1:0] y_data;
    logic             y_last;
    logic             y_ready;

    logic             s;
    logic             busy;

    modport slave (
        input  a0_valid, a0_data, a0_last,
        output a0_ready,
        input  a1_valid, a1_data, a1_last,
        output a1_ready,
        output y_valid, y_data, y_last,
        input  y_ready,
        output s, busy
    );

    modport master (
        output a0_valid, a0_data, a0_last,
        input  a0_ready,
        output a1_valid, a1_data, a1_last,
        input  a1_ready,
        input  y_valid, y_data, y_last,
        output y_ready,
        input  s, busy
    );
endinterface

// File: rtl/mux2x1_burst_arbiter.sv
// Two-source burst arbiter: grants one source for a whole burst (ended by a
// last-beat handshake) and rotates priority round-robin between bursts.
// Optional build macro MUX2X1_ARB_FIXED_PRIORITY_EN: source 0 wins every tie.
module mux2x1_burst_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    mux2x1_burst_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s;
    logic             w_s_nxt;
    logic             r_last_gnt;
    logic             w_last_gnt_nxt;
    logic             r_busy;
    logic             w_arb;
    logic             w_any;
    logic             w_winner;
    logic [WIDTH-1:0] w_y_data;

    // Pick the winner among the sources valid this cycle
    always_comb begin
        w_any    = bus.a0_valid | bus.a1_valid;
        w_winner = 1'b0;
        if (bus.a0_valid && bus.a1_valid) begin
`ifdef MUX2X1_ARB_FIXED_PRIORITY_EN
            w_winner = 1'b0;
`else
            w_winner = ~r_last_gnt;
`endif
        end else begin
            w_winner = bus.a1_valid;
        end
    end

    // Next state: arbitrate in IDLE and on the last-beat handshake of a burst
    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_last_gnt_nxt = r_last_gnt;
        w_arb          = 1'b0;
        unique case (r_state)
            ST_IDLE: w_arb = 1'b1;
            ST_GNT0: w_arb = bus.a0_valid & bus.y_ready & bus.a0_last;
            ST_GNT1: w_arb = bus.a1_valid & bus.y_ready & bus.a1_last;
            default: w_arb = 1'b1;
        endcase
        if (w_arb) begin
            if (w_any) begin
                w_state_nxt    = w_winner ? ST_GNT1 : ST_GNT0;
                w_s_nxt        = w_winner;
                w_last_gnt_nxt = w_winner;
            end else begin
                w_state_nxt    = ST_IDLE;
                w_s_nxt        = 1'b0;
            end
        end
    end

    // State, select, priority pointer and busy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_s        <= 1'b0;
            r_last_gnt <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_last_gnt <= w_last_gnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Combinational handshake routing for the granted source
    always_comb begin
        bus.y_valid  = 1'b0;
        bus.y_last   = 1'b0;
        bus.a0_ready = 1'b0;
        bus.a1_ready = 1'b0;
        w_y_data     = r_s ? bus.a1_data : bus.a0_data;
        unique case (r_state)
            ST_GNT0: begin
                bus.y_valid  = bus.a0_valid;
                bus.y_last   = bus.a0_last;
                bus.a0_ready = bus.y_ready;
            end
            ST_GNT1: begin
                bus.y_valid  = bus.a1_valid;
                bus.y_last   = bus.a1_last;
                bus.a1_ready = bus.y_ready;
            end
            default: ;
        endcase
    end

    assign bus.y_data = w_y_data;
    assign bus.s      = r_s;
    assign bus.busy   = r_busy;

endmodule
